// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out rename tags at dispatch, collects CDB results,
// and retires entries in order through the register file's shared load/allocate port.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    input  logic [4:0]       alloc_dest,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic [TAG_W-1:0] qry_tag_a,
    input  logic [TAG_W-1:0] qry_tag_b,
    output logic             qry_rdy_a,
    output logic             qry_rdy_b,
    output logic [31:0]      qry_val_a,
    output logic [31:0]      qry_val_b,
    input  logic             flush,
    output logic             rf_load,
    output logic             rf_allocate,
    output logic [4:0]       rf_dest,
    output logic [31:0]      rf_in,
    output logic [TAG_W-1:0] rf_tag,
    output logic             empty,
    output logic             full
);

    localparam int CNT_W = TAG_W + 1;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] done_r;
    logic [4:0]       dest_r  [DEPTH];
    logic [31:0]      value_r [DEPTH];
    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             ready_r;
    logic             commit_en_s;
    logic             alloc_fire_s;

    // Commit owns the regfile port whenever the head is retirable; allocation waits.
    assign commit_en_s  = busy_r[head_r] && done_r[head_r] && !flush;
    assign full         = (count_r == CNT_W'(DEPTH));
    assign empty        = (count_r == {CNT_W{1'b0}});
    assign alloc_ready  = ready_r && !full && !commit_en_s && !flush;
    assign alloc_fire_s = alloc_req && alloc_ready;
    assign alloc_tag    = tail_r;
    assign rf_tag       = tail_r;
    assign rf_load      = commit_en_s;
    assign rf_allocate  = alloc_fire_s;
    assign rf_in        = value_r[head_r];

    assign qry_rdy_a = busy_r[qry_tag_a] && done_r[qry_tag_a];
    assign qry_rdy_b = busy_r[qry_tag_b] && done_r[qry_tag_b];
    assign qry_val_a = value_r[qry_tag_a];
    assign qry_val_b = value_r[qry_tag_b];

    // Shared destination port mux: retiring entry first, then the dispatching instruction.
    always_comb begin
        rf_dest = 5'd0;
        if (commit_en_s) begin
            rf_dest = dest_r[head_r];
        end else if (alloc_fire_s) begin
            rf_dest = alloc_dest;
        end else begin
            rf_dest = 5'd0;
        end
    end

    // Entry storage, pointers and occupancy; flush discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r  <= {DEPTH{1'b0}};
            done_r  <= {DEPTH{1'b0}};
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_r[i]  <= 5'd0;
                value_r[i] <= 32'd0;
            end
        end else if (flush) begin
            busy_r  <= {DEPTH{1'b0}};
            done_r  <= {DEPTH{1'b0}};
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            ready_r <= 1'b1;
        end else begin
            ready_r <= 1'b1;
            if (cdb_valid && busy_r[cdb_tag]) begin
                value_r[cdb_tag] <= cdb_data;
                done_r[cdb_tag]  <= 1'b1;
            end
            // Commit clears come after writeback so a retiring entry always ends idle.
            if (commit_en_s) begin
                busy_r[head_r] <= 1'b0;
                done_r[head_r] <= 1'b0;
                head_r         <= head_r + TAG_W'(1);
                count_r        <= count_r - CNT_W'(1);
            end else if (alloc_fire_s) begin
                busy_r[tail_r] <= 1'b1;
                done_r[tail_r] <= 1'b0;
                dest_r[tail_r] <= alloc_dest;
                tail_r         <= tail_r + TAG_W'(1);
                count_r        <= count_r + CNT_W'(1);
            end
        end
    end

endmodule
